// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared constants and types for the convolutional encoder and the
// Viterbi decoder blocks (BMC/ACS), so both ends of the link use the same trellis.
//   K_DEF       constraint length (state register is K_DEF-1 bits)
//   G0_DEF      generator for code bit 0 (octal 171)
//   G1_DEF      generator for code bit 1 (octal 133)
//   pair_t      one 2-bit code symbol {G1 parity, G0 parity}
//   enc_state_t encoder framing FSM states
package viterbi_pkg;

   localparam int unsigned K_DEF  = 7;
   localparam logic [6:0]  G0_DEF = 7'o171;
   localparam logic [6:0]  G1_DEF = 7'o133;

   typedef logic [1:0] pair_t;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      TAIL
   } enc_state_t;

endpackage

// File: rtl/conv_parity.sv
// conv_parity: one generator tap of a convolutional encoder, i.e. the XOR
// reduction of the encoding window masked by the generator polynomial.
// Ports:
//   window  [K-1:0] in   {current bit, shift register}; MSB is the newest bit
//   gen     [K-1:0] in   generator polynomial
//   parity          out  ^(window & gen)
module conv_parity #(
   parameter int unsigned K = 7
) (
   input  logic [K-1:0] window,
   input  logic [K-1:0] gen,
   output logic         parity
);

   assign parity = ^(window & gen);

endmodule

// File: rtl/conv_encoder_tx.sv
// conv_encoder_tx: streaming rate-1/2, constraint-length-K convolutional encoder.
// Takes one information bit per input handshake and emits one registered 2-bit
// symbol per output handshake. After the bit flagged in_last, K-1 zero tail bits
// are pushed through so the trellis ends in state 0; the last tail symbol carries
// out_last.
// Ports:
//   clk, rst   clock (rising edge), synchronous active-high reset
//   in_valid   in_bit is valid
//   in_bit     information bit
//   in_last    final data bit of a frame (ignored when in_valid is low)
//   in_ready   encoder accepts in_bit this cycle
//   out_valid  out_pair is valid
//   out_pair   code symbol {G1 parity, G0 parity}
//   out_last   final tail symbol of a frame
//   out_ready  downstream accepts the symbol
//   busy       frame in progress (DATA or TAIL); ignores the output register
//   out_mask   (only with CONV_PUNCTURE_EN) rate-2/3 erasure mask, 11 or 01
// Build option: define CONV_PUNCTURE_EN to add the out_mask puncturing output.
module conv_encoder_tx
   import viterbi_pkg::*;
#(
   parameter int unsigned K  = K_DEF,
   parameter logic [K-1:0] G0 = G0_DEF,
   parameter logic [K-1:0] G1 = G1_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic       in_bit,
   input  logic       in_last,
   output logic       in_ready,
   output logic       out_valid,
   output pair_t      out_pair,
   output logic       out_last,
   input  logic       out_ready,
   output logic       busy
`ifdef CONV_PUNCTURE_EN
   ,
   output logic [1:0] out_mask
`endif
);

   // Tail counter runs 0..K-2.
   localparam int unsigned CntW = (K > 2) ? $clog2(K - 1) : 1;

   enc_state_t      state_q, state_d;
   logic [K-2:0]    sr_q, sr_d;
   logic [CntW-1:0] tail_cnt_q, tail_cnt_d;
   logic            out_valid_q, out_valid_d;
   pair_t           out_pair_q, out_pair_d;
   logic            out_last_q, out_last_d;

   logic            load;
   logic            accept;
   logic            gen;
   logic            cur_bit;
   logic            tail_end;
   logic [K-1:0]    window;
   pair_t           parity;

   // Output register is free, or is being drained this cycle.
   assign load     = !out_valid_q || out_ready;
   assign in_ready = load && (state_q != TAIL);
   assign accept   = in_valid && in_ready;
   // Tail symbols are self-timed: no input handshake, only output space.
   assign gen      = accept || (load && (state_q == TAIL));
   assign cur_bit  = (state_q == TAIL) ? 1'b0 : in_bit;
   assign window   = {cur_bit, sr_q};
   assign tail_end = (tail_cnt_q == CntW'(K - 2));

   conv_parity #(
      .K (K)
   ) u_parity_g0 (
      .window (window),
      .gen    (G0),
      .parity (parity[0])
   );

   conv_parity #(
      .K (K)
   ) u_parity_g1 (
      .window (window),
      .gen    (G1),
      .parity (parity[1])
   );

   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      tail_cnt_d  = tail_cnt_q;
      out_valid_d = out_valid_q;
      out_pair_d  = out_pair_q;
      out_last_d  = out_last_q;

      if (gen) begin
         out_valid_d = 1'b1;
         out_pair_d  = parity;
         out_last_d  = (state_q == TAIL) && tail_end;
         sr_d        = window[K-1:1];
      end else if (load) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end

      unique case (state_q)
         IDLE, DATA: begin
            if (accept) begin
               state_d = in_last ? TAIL : DATA;
            end
         end
         TAIL: begin
            if (gen) begin
               if (tail_end) begin
                  state_d    = IDLE;
                  tail_cnt_d = '0;
               end else begin
                  tail_cnt_d = tail_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sr_q        <= '0;
         tail_cnt_q  <= '0;
         out_valid_q <= 1'b0;
         out_pair_q  <= 2'b00;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         tail_cnt_q  <= tail_cnt_d;
         out_valid_q <= out_valid_d;
         out_pair_q  <= out_pair_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_pair  = out_pair_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q != IDLE);

`ifdef CONV_PUNCTURE_EN
   logic       phase_q, phase_d;
   logic [1:0] mask_q, mask_d;
   logic       phase_cur;

   // A frame's first symbol always uses phase 0.
   assign phase_cur = (state_q == IDLE) ? 1'b0 : phase_q;

   always_comb begin
      phase_d = phase_q;
      mask_d  = mask_q;
      if (gen) begin
         mask_d  = phase_cur ? 2'b01 : 2'b11;
         phase_d = !phase_cur;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q <= 1'b0;
         mask_q  <= 2'b11;
      end else begin
         phase_q <= phase_d;
         mask_q  <= mask_d;
      end
   end

   assign out_mask = mask_q;
`endif

endmodule

// File: tb/tb_conv_encoder_tx.sv
// tb_conv_encoder_tx: directed self-checking bench for conv_encoder_tx.
// Expected symbol streams are hand-computed from G0=171, G1=133 (octal).
module tb_conv_encoder_tx;
   import viterbi_pkg::*;

   logic  clk       = 1'b0;
   logic  rst       = 1'b1;
   logic  in_valid  = 1'b0;
   logic  in_bit    = 1'b0;
   logic  in_last   = 1'b0;
   logic  out_ready = 1'b1;
   logic  in_ready;
   logic  out_valid;
   pair_t out_pair;
   logic  out_last;
   logic  busy;
   logic [1:0] mask_obs;

   int   tests = 0;
   int   fails = 0;
   logic stall = 1'b0;
   // Captured symbols: {mask[1:0], last, pair[1:0]}
   logic [4:0] q[$];

`ifdef CONV_PUNCTURE_EN
   logic [1:0] out_mask;
   assign mask_obs = out_mask;
`else
   assign mask_obs = 2'b11;
`endif

   conv_encoder_tx dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_pair  (out_pair),
      .out_last  (out_last),
      .out_ready (out_ready),
      .busy      (busy)
`ifdef CONV_PUNCTURE_EN
      ,
      .out_mask  (out_mask)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Output monitor: record handshaken symbols, check stability while stalled.
   logic       prev_hold = 1'b0;
   logic [2:0] prev_sym  = 3'b000;
   always @(posedge clk) begin
      if (rst) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) chk("hold_stable", {29'd0, out_last, out_pair}, {29'd0, prev_sym});
         if (out_valid && out_ready) q.push_back({mask_obs, out_last, out_pair});
         prev_hold = out_valid && !out_ready;
         prev_sym  = {out_last, out_pair};
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (stall) out_ready = ~out_ready;
      #1;
      if (!rst && out_valid && !out_ready) chk("in_ready_stall", {31'd0, in_ready}, 32'd0);
   endtask

   task automatic send_bit(input logic b, input logic l);
      logic ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_bit   = b;
      in_last  = l;
      for (int i = 0; i < 100 && !ok; i++) begin
         if (in_ready) ok = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      in_bit   = 1'b0;
      in_last  = 1'b0;
      chk("accept_timeout", {31'd0, ok}, 32'd1);
   endtask

   task automatic wait_syms(input int n);
      for (int i = 0; i < 300 && q.size() < n; i++) tick();
      for (int i = 0; i < 4; i++) tick();
      chk("sym_count", q.size(), n);
   endtask

   logic [1:0] exp_one[7] = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b10, 2'b11};
   logic [1:0] exp_101[9] = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11};

   initial begin
      #1000000;
      $display("FAIL watchdog tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      int lasts;
      // Reset state
      rst = 1'b1;
      tick();
      tick();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_pair", {30'd0, out_pair}, 32'd0);
      chk("rst_out_last", {31'd0, out_last}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Single "1" frame: impulse response, 1-cycle latency
      q.delete();
      send_bit(1'b1, 1'b1);
      chk("t1_latency_valid", {31'd0, out_valid}, 32'd1);
      chk("t1_latency_pair", {30'd0, out_pair}, 32'd3);
      chk("t1_busy_tail", {31'd0, busy}, 32'd1);
      wait_syms(7);
      for (int i = 0; i < 7; i++) begin
         chk($sformatf("t1_sym%0d", i), {29'd0, q[i][2:0]}, {29'd0, (i == 6), exp_one[i]});
`ifdef CONV_PUNCTURE_EN
         chk($sformatf("t1_mask%0d", i), {30'd0, q[i][4:3]},
             (i % 2 == 1) ? 32'd1 : 32'd3);
`endif
      end
      chk("t1_busy_after", {31'd0, busy}, 32'd0);
      chk("t1_sr_zero", {26'd0, dut.sr_q}, 32'd0);

      // All-zero 8-bit frame -> 14 zero symbols
      q.delete();
      for (int i = 0; i < 8; i++) send_bit(1'b0, (i == 7));
      wait_syms(14);
      for (int i = 0; i < 14; i++)
         chk($sformatf("t2_sym%0d", i), {29'd0, q[i][2:0]}, {29'd0, (i == 13), 2'b00});

      // Frame 1,0,1 with out_ready toggling every cycle
      q.delete();
      out_ready = 1'b1;
      stall     = 1'b1;
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b1);
      wait_syms(9);
      stall     = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("t3_count_final", q.size(), 9);
      for (int i = 0; i < 9; i++)
         chk($sformatf("t3_sym%0d", i), {29'd0, q[i][2:0]}, {29'd0, (i == 8), exp_101[i]});

      // Reset in TAIL at tail_cnt=3
      send_bit(1'b1, 1'b1);
      tick();
      tick();
      tick();
      chk("t4_tail_cnt", {29'd0, dut.tail_cnt_q}, 32'd3);
      chk("t4_busy_pre", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      tick();
      chk("t4_out_valid", {31'd0, out_valid}, 32'd0);
      chk("t4_busy", {31'd0, busy}, 32'd0);
      chk("t4_in_ready", {31'd0, in_ready}, 32'd1);
      rst = 1'b0;
      q.delete();
      send_bit(1'b1, 1'b1);
      wait_syms(7);
      chk("t4_first_sym", {29'd0, q[0][2:0]}, 32'd3);
      chk("t4_last_sym", {29'd0, q[6][2:0]}, 32'd7);

      // Back-to-back frames "1" | "1"
      q.delete();
      send_bit(1'b1, 1'b1);
      send_bit(1'b1, 1'b1);
      wait_syms(14);
      lasts = 0;
      for (int i = 0; i < q.size(); i++) if (q[i][2]) lasts++;
      chk("t5_last_pulses", lasts, 2);
      chk("t5_f1_last", {29'd0, q[6][2:0]}, 32'd7);
      chk("t5_f2_first", {29'd0, q[7][2:0]}, 32'd3);
      chk("t5_f2_last", {29'd0, q[13][2:0]}, 32'd7);
`ifdef CONV_PUNCTURE_EN
      chk("t5_f2_mask0", {30'd0, q[7][4:3]}, 32'd3);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
